// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, sequences multi-cycle
// MULT/MULTU/DIV/DIVU, and raises the D-stage stall while HI/LO are occupied.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;

  logic [63:0] prod_s, prod_u;
  logic        div_by_zero, rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, rt_mag_safe, rt_safe;
  logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
  logic        long_start;

  // Arithmetic datapath; signed divide works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    prod_s      = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u      = {32'd0, rs_val} * {32'd0, rt_val};
    div_by_zero = (rt_val == 32'd0);
    rs_neg      = rs_val[31];
    rt_neg      = rt_val[31];
    rs_mag      = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag      = rt_neg ? (32'd0 - rt_val) : rt_val;
    rt_mag_safe = div_by_zero ? 32'd1 : rt_mag;
    rt_safe     = div_by_zero ? 32'd1 : rt_val;
    q_mag       = rs_mag / rt_mag_safe;
    r_mag       = rs_mag % rt_mag_safe;
    quot_s      = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    rem_s       = rs_neg ? (32'd0 - r_mag) : r_mag;
    quot_u      = rs_val / rt_safe;
    rem_u       = rs_val % rt_safe;
  end

  assign long_start = start & (md_op >= OP_MULT) & (md_op <= OP_DIVU);

  // Next-state and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    dz_d      = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (md_op)
            OP_MULT: begin
              {temp_hi_d, temp_lo_d} = prod_s;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_MULTU: begin
              {temp_hi_d, temp_lo_d} = prod_u;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV: begin
              temp_hi_d = rem_s;
              temp_lo_d = quot_s;
              dz_d      = div_by_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIVU: begin
              temp_hi_d = rem_u;
              temp_lo_d = quot_u;
              dz_d      = div_by_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = d_uses_md & (busy_q | long_start);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: arithmetic results, busy timing, stall, MTHI/MTLO,
// ignored starts and reset abort.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int errs    = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_uses_md(d_uses_md),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launch a multi-cycle op and follow it through n busy cycles to commit.
  task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic dum,
                          input logic [31:0] hi_pre, input logic [31:0] lo_pre);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_uses_md = dum;
    #1 check({tag, " stall_at_start"}, 32'(stall), 32'(dum));
    cyc();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " stall_busy"}, 32'(stall), 32'(dum));
      check({tag, " hi_hold"}, hi, hi_pre);
      check({tag, " lo_hold"}, lo, lo_pre);
      cyc();
    end
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " stall_end"}, 32'(stall), 32'd0);
    d_uses_md = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0; d_uses_md = 1'b0;
    cyc(); cyc();
    check("init_hi", hi, 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Scribble HI/LO, then reset for two cycles.
    start = 1'b1; md_op = 3'd5; rs_val = 32'hA5A5A5A5; cyc();
    md_op = 3'd6; rs_val = 32'h5A5A5A5A; cyc();
    start = 1'b0;
    check("pre_reset_hi", hi, 32'hA5A5A5A5);
    check("pre_reset_lo", lo, 32'h5A5A5A5A);
    reset = 1'b1; d_uses_md = 1'b1; cyc();
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    cyc();
    reset = 1'b0; d_uses_md = 1'b0;

    run_long("mult", 3'd1, 32'hFFFFFFFE, 32'h00000003, 5, 1'b1, 32'd0, 32'd0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    // MULTU with an illegal MULT start injected mid-flight; it must be ignored.
    start = 1'b1; md_op = 3'd2; rs_val = 32'hFFFFFFFE; rt_val = 32'h3; d_uses_md = 1'b0;
    #1 check("multu_stall_start", 32'(stall), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      start = (i == 1); md_op = 3'd1; rs_val = 32'd5; rt_val = 32'd7;
      #1;
      check("multu_busy", 32'(busy), 32'd1);
      check("multu_stall_nouse", 32'(stall), 32'd0);
      check("multu_hi_hold", hi, 32'hFFFFFFFF);
      cyc();
    end
    start = 1'b0;
    check("multu_busy_end", 32'(busy), 32'd0);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);
    cyc();
    check("multu_no_restart", 32'(busy), 32'd0);

    run_long("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'h2, 32'hFFFFFFFA);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);

    run_long("divu", 3'd4, 32'd7, 32'd2, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd3);

    run_long("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'd1, 32'd3);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_lo", lo, 32'h80000000);

    // MTHI with a dependent D-stage instruction never stalls.
    start = 1'b1; md_op = 3'd5; rs_val = 32'h11; d_uses_md = 1'b1;
    #1 check("mthi_stall", 32'(stall), 32'd0);
    cyc();
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", 32'(busy), 32'd0);
    md_op = 3'd6; rs_val = 32'h22; d_uses_md = 1'b0; cyc();
    start = 1'b0;
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_hi", hi, 32'h11);

    run_long("div0", 3'd3, 32'd5, 32'd0, 10, 1'b1, 32'h11, 32'h22);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    run_long("divu0", 3'd4, 32'd9, 32'd0, 10, 1'b0, 32'h11, 32'h22);
    check("divu0_lo", lo, 32'h22);

    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEADBEEF; cyc();
    start = 1'b0;
    check("mtlo2_lo", lo, 32'hDEADBEEF);
    check("mtlo2_hi", hi, 32'h11);
    check("mtlo2_busy", 32'(busy), 32'd0);

    // Reserved and NONE opcodes do nothing, even with a dependent D-stage op.
    start = 1'b1; md_op = 3'd7; rs_val = 32'h0BADF00D; rt_val = 32'd3; d_uses_md = 1'b1;
    #1 check("op7_stall", 32'(stall), 32'd0);
    cyc();
    md_op = 3'd0; cyc();
    start = 1'b0; d_uses_md = 1'b0;
    check("op_ign_hi", hi, 32'h11);
    check("op_ign_lo", lo, 32'hDEADBEEF);
    check("op_ign_busy", 32'(busy), 32'd0);

    // Reset during busy cycle 4 of a DIV discards the op.
    start = 1'b1; md_op = 3'd3; rs_val = 32'hFFFFFFF9; rt_val = 32'd2; cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1; cyc();
    reset = 1'b0; d_uses_md = 1'b1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 8; i++) cyc();
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit with its sequencing controller for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as multi-cycle operations with a busy counter. MTHI/MTLO are single-cycle writes.
- Produces the D-stage stall request for any instruction that touches HI/LO while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (valid range >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (valid range >=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is a valid md op this cycle.
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / MTxx source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- d_uses_md  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- busy  output  1  multi-cycle op in progress.
- stall  output  1  freeze PC and F/D, bubble into E.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset state:
  - Reset is synchronous. In the cycle after reset is sampled high: hi=0, lo=0, busy=0, counter=0, FSM=IDLE.
  - Reset has priority over start and over any in-flight op. An interrupted op is discarded and does not commit.
- FSM has two states, IDLE and RUN.
- IDLE, on start with md_op in 1..4:
  - Latch the result into temp_hi/temp_lo at the sampling edge. Both products and quotients are computed combinationally from rs_val/rt_val.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN:
  - busy=1 and counter decrements each edge.
  - On the edge where counter==1: hi<=temp_hi, lo<=temp_lo, busy falls, go to IDLE.
  - Net effect: an op started at edge k updates hi/lo and clears busy at edge k+N. busy is high for exactly N cycles.
- MTHI/MTLO (md_op 5/6 with start):
  - hi<=rs_val or lo<=rs_val at the next edge.
  - busy stays 0 and there is no RUN state.
- start while busy=1 cannot occur legally because stall prevents it. If it occurs, it is ignored: no state change and no reload.
- md_op 0 or 7 with start is ignored.
- Arithmetic:
  - MULT gives {hi,lo} = signed 32x32 -> 64-bit product. MULTU gives the unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient to lo, unsigned remainder to hi.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
  - Divisor == 0 (DIV/DIVU): the op still takes DIV_CYCLES with busy=1, but hi/lo remain unchanged at commit.
- stall = d_uses_md & (busy | (start & md_op in 1..4)). It is combinational.
- hi/lo are register outputs. An MFHI/MFLO reaching E after stall releases sees committed values. There is no bypass of temp values.
- The block has no flush input; the pipeline never kills an E-stage md op.

Test Plan:
- Reset: assert reset 2 cycles after random writes -> hi=lo=0, busy=0, stall=0 on the first cycle after reset.
- MULT: rs=0xFFFFFFFE (-2), rt=0x00000003, start at edge k -> busy=1 for cycles k..k+4; at edge k+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with rs=7, rt=2 -> lo=3, hi=1. DIV by 0 with hi=0x11, lo=0x22 preloaded -> busy for 10 cycles, then hi=0x11, lo=0x22.
- Stall:
  - d_uses_md=1 in the same cycle as a MULT start -> stall=1 for that cycle plus the 5 busy cycles, 0 after.
  - d_uses_md=0 during busy -> stall=0.
  - MTHI start with d_uses_md=1 -> stall=0.
- MTHI/MTLO: MTLO rs=0xDEADBEEF -> lo=0xDEADBEEF next edge, hi unchanged, busy never asserted. start with MULT while busy -> counter and temp unchanged; original result commits on schedule.
- Reset mid-op: DIV started, reset asserted at busy cycle 4 -> hi=lo=0, busy=0 next edge, and no late commit at the original k+10.
